// File: rtl/bcd_serial_accumulator.sv
// Packed-BCD accumulator: adds or subtracts an operand one decimal digit per clock, LSD first.
// Carry-out on add and borrow on subtract are tallied in a saturating wrap counter.
module bcd_serial_accumulator #(
    parameter int DIGITS = 4,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sub,
    input  logic [4*DIGITS-1:0] in_operand,
    output logic [4*DIGITS-1:0] acc,
    output logic                out_valid,
    output logic                out_carry,
    output logic                out_err,
    output logic                zero,
    output logic [CNT_W-1:0]    wrap_count
);
    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       acc_q, acc_d;
    logic [W-1:0]       work_q, work_d;
    logic [W-1:0]       op_q, op_d;
    logic               sub_q, sub_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               flag_q, flag_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   wrap_q, wrap_d;

    logic [3:0] dig_a, dig_op, dig_b, dig_sum;
    logic [4:0] sum_raw, sum_adj;
    logic       dig_cout, new_flag;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Subtraction is done as acc + nines-complement(operand) + 1.
    always_comb begin
        dig_a   = work_q[idx_q*4 +: 4];
        dig_op  = op_q[idx_q*4 +: 4];
        dig_b   = sub_q ? (4'd9 - dig_op) : dig_op;
        sum_raw = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0, carry_q};
        sum_adj = sum_raw - 5'd10;
        if (sum_raw >= 5'd10) begin
            dig_sum  = sum_adj[3:0];
            dig_cout = 1'b1;
        end else begin
            dig_sum  = sum_raw[3:0];
            dig_cout = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        work_d   = work_q;
        op_d     = op_q;
        sub_d    = sub_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        flag_d   = flag_q;
        err_d    = err_q;
        wrap_d   = wrap_q;
        new_flag = 1'b0;
        in_ready = (state_q == S_IDLE) && !clr;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    op_d  = in_operand;
                    sub_d = in_sub;
                    if (has_bad_digit(in_operand)) begin
                        err_d   = 1'b1;
                        flag_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        work_d  = acc_q;
                        idx_d   = '0;
                        carry_d = in_sub;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                work_d[idx_q*4 +: 4] = dig_sum;
                carry_d = dig_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    new_flag = sub_q ? ~dig_cout : dig_cout;
                    acc_d    = work_d;
                    flag_d   = new_flag;
                    err_d    = 1'b0;
                    if (new_flag && (wrap_q != {CNT_W{1'b1}})) wrap_d = wrap_q + 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (clr) begin
            state_d = S_IDLE;
            acc_d   = '0;
            wrap_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            work_q  <= '0;
            op_q    <= '0;
            sub_q   <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            flag_q  <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            work_q  <= work_d;
            op_q    <= op_d;
            sub_q   <= sub_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            flag_q  <= flag_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    assign acc        = acc_q;
    assign out_valid  = (state_q == S_DONE);
    assign out_carry  = flag_q;
    assign out_err    = err_q;
    assign zero       = (acc_q == '0);
    assign wrap_count = wrap_q;
endmodule

// File: doc/bcd_serial_accumulator.md
# bcd_serial_accumulator

Multi-digit packed-BCD accumulator that adds or subtracts a DIGITS-wide BCD operand into a running total, one decimal digit per clock (LSD first), with valid/ready input handshake. Result wraps modulo 10^DIGITS; every carry-out (add) or borrow (subtract) is counted in a saturating wrap counter. It is the sequential, parametrised successor to our single-digit combinational BCD adder, used for decimal dial/counter puzzles where the position wraps and wrap events are tallied.

## Interface
- DIGITS, 4, number of BCD digits in accumulator and operand (≥1)
- CNT_W, 16, width of wrap counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear of acc, wrap_count, and any in-flight op
- in_valid  in  1  operand offered
- in_ready  out  1  block can accept operand
- in_sub  in  1  0 = acc + operand, 1 = acc − operand
- in_operand  in  4*DIGITS  packed BCD, digit 0 in [3:0]
- acc  out  4*DIGITS  committed accumulator value
- out_valid  out  1  one-cycle pulse: op finished
- out_carry  out  1  add: carry out of MSD; sub: borrow; valid with out_valid
- out_err  out  1  operand had a digit >9; valid with out_valid
- zero  out  1  acc == 0 (continuous)
- wrap_count  out  CNT_W  saturating count of ops with out_carry=1

## Operation
- States: IDLE, RUN, DONE. in_ready = (state==IDLE) && !clr. out_valid = (state==DONE).
- IDLE: on in_valid && in_ready, latch operand and in_sub. If any operand digit >9: go DONE with err=1, acc unchanged, wrap_count unchanged. Else copy acc to work register, idx=0, carry=in_sub, go RUN.
- RUN, each cycle on digit idx: a = work digit, b = in_sub ? 9−op digit : op digit; s = a+b+carry (5-bit, max 19). s≥10: digit=s−10, carry=1; else digit=s, carry=0. Write digit into work, idx++.
- On the edge processing idx=DIGITS−1: acc ← full work result (new MSD included), flag = in_sub ? ~carry : carry, err=0, go DONE.
- DONE (one cycle): out_carry=flag, out_err=err. wrap_count increments if flag=1, saturating at 2^CNT_W−1. Next state IDLE.
- Subtraction is ten's complement: result = (acc − operand) mod 10^DIGITS; borrow=1 iff operand > acc.
- acc never shows a partially updated value; it changes only on the final RUN edge.
- clr (any state): acc=0, wrap_count=0, state=IDLE, in-flight op discarded, no out_valid. clr wins over a simultaneous in_valid (not accepted).
- out_carry/out_err hold last values outside DONE; only meaningful with out_valid.

## Timing
- rst asserted: state=IDLE, acc=0, wrap_count=0, out_valid=0, out_carry=0, out_err=0, zero=1, in_ready=1 (when clr=0).
- Accept at edge E0. Valid op: RUN during E0..E_DIGITS, acc updated at edge E_DIGITS, out_valid high for the cycle after E_DIGITS. Latency DIGITS+1 cycles from accept to out_valid.
- Error op: out_valid high in the cycle right after E0.
- Throughput: one op per DIGITS+2 cycles. in_ready low in RUN and DONE and rises in the cycle after out_valid. An in_valid held high is accepted on that first IDLE cycle.
- Operand and in_sub need to be stable only at the accept edge.
- rst mid-op aborts immediately to reset values.
- zero and wrap_count update on the same edge as acc / DONE entry respectively.

## Test plan
- Reset then add 1234 (DIGITS=4) -> out_valid 5 cycles after accept, acc=0x1234, out_carry=0, zero=0, wrap_count=0.
- acc=9999, add 0001 -> acc=0x0000, out_carry=1, zero=1, wrap_count=1. Repeat with add 0000 -> out_carry=0, wrap_count stays 1.
- acc=0005, subtract 0007 -> acc=0x9998, out_carry=1 (borrow). Then subtract 9998 -> acc=0x0000, out_carry=0, zero=1.
- acc=0x0042, operand 0x00A0 -> out_valid in cycle after accept, out_err=1, acc stays 0x0042, wrap_count unchanged. Next valid op -> out_err=0.
- clr asserted on 2nd RUN cycle of add 0x0100 to 0x0900 -> no out_valid, acc=0, wrap_count=0, in_ready=1 the cycle after clr drops. Also assert rst mid-RUN -> reset values immediately.
- CNT_W=2, four carry-producing adds back-to-back with in_valid held high -> accepts spaced exactly DIGITS+2 cycles, wrap_count saturates at 3.
